// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: generates sclk from a runtime half-period divider and
// emits registered edge, sample/shift and end-of-frame strobes aligned with sclk.
// Optional macro SPI_SCLK_ENGINE_GUARD_EN adds a post-frame guard interval of
// div+1 cycles (sclk held idle) before done, for chip-select hold time.
module spi_sclk_engine #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  output logic             sclk,
  output logic             busy,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             done
);

`ifdef SPI_SCLK_ENGINE_GUARD_EN
  typedef enum logic [1:0] {StIdle, StRun, StGuard, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W:0]   ecnt_q, ecnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;

  // Next-state: frame sequencing, half-period timing and edge strobes.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lead_d   = 1'b0;
    trail_d  = 1'b0;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        hcnt_d = '0;
        ecnt_d = '0;
        if (start) begin
          div_d   = div;
          nbits_d = nbits;
          cpol_d  = cpol;
          cpha_d  = cpha;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Frame ends once 2*nbits edges have been produced (immediately for nbits=0).
        if (ecnt_q == {nbits_q, 1'b0}) begin
`ifdef SPI_SCLK_ENGINE_GUARD_EN
          hcnt_d  = '0;
          state_d = StGuard;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
`endif
        end else if (hcnt_q == div_q) begin
          hcnt_d  = '0;
          sclk_d  = ~sclk_q;
          ecnt_d  = ecnt_q + 1'b1;
          // Even edge index is leading, odd is trailing.
          lead_d   = ~ecnt_q[0];
          trail_d  = ecnt_q[0];
          sample_d = cpha_q ? ecnt_q[0] : ~ecnt_q[0];
          shift_d  = cpha_q ? ~ecnt_q[0] : ecnt_q[0];
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
`ifdef SPI_SCLK_ENGINE_GUARD_EN
      StGuard: begin
        if (hcnt_q == div_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lead_q   <= lead_d;
      trail_q  <= trail_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
    end
  end

  assign sclk       = sclk_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign lead_stb   = lead_q;
  assign trail_stb  = trail_q;
  assign sample_stb = sample_q;
  assign shift_stb  = shift_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: directed and random frames compared
// cycle by cycle against an arithmetic edge-timing model.
module tb_spi_sclk_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cpol;
  logic        cpha;
  logic [15:0] div_i;
  logic [5:0]  nbits_i;
  logic        sclk, busy, lead_stb, trail_stb, sample_stb, shift_stb, done;

  int n_cmp = 0;
  int n_bad = 0;

  spi_sclk_engine #(.DIV_W(16), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cpol       (cpol),
    .cpha       (cpha),
    .div        (div_i),
    .nbits      (nbits_i),
    .sclk       (sclk),
    .busy       (busy),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Cycle (relative to start-sampling cycle T) in which done pulses.
  function automatic int done_cycle(input int d, input int n);
    int dc;
    dc = (n == 0) ? 2 : (d + 2) + (2 * n - 1) * (d + 1) + 1;
`ifdef SPI_SCLK_ENGINE_GUARD_EN
    dc = dc + d + 1;
`endif
    return dc;
  endfunction

  // Expected {sclk,busy,lead,trail,sample,shift,done} in cycle T+k.
  function automatic logic [6:0] model(input int k, input int d, input int n,
                                       input bit pol, input bit pha);
    int   e0, sp, ne, idx, seen, dc;
    bit   on_edge, lead, trail, smp, shf, sc;
    e0 = d + 2;
    sp = d + 1;
    ne = 2 * n;
    dc = done_cycle(d, n);
    on_edge = 1'b0;
    seen = 0;
    idx = 0;
    if (ne != 0 && k >= e0) begin
      idx  = (k - e0) / sp;
      seen = (idx + 1 < ne) ? idx + 1 : ne;
      on_edge = ((k - e0) % sp == 0) && (idx < ne);
    end
    lead  = on_edge && (idx % 2 == 0);
    trail = on_edge && (idx % 2 == 1);
    smp   = pha ? trail : lead;
    shf   = pha ? lead : trail;
    sc    = pol ^ seen[0];
    return {sc, (k >= 1 && k < dc), lead, trail, smp, shf, (k == dc)};
  endfunction

  task automatic check(input string tag, input logic [6:0] exp_v);
    logic [6:0] obs;
    obs = {sclk, busy, lead_stb, trail_stb, sample_stb, shift_stb, done};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b (sclk,busy,lead,trail,sample,shift,done)",
             tag, $time, obs, exp_v);
    end
  endtask

  // Runs one frame starting at the current negedge; abort_at>0 stops checking early.
  task automatic run_frame(input int d, input int n, input bit pol, input bit pha,
                           input bit hold, input int abort_at);
    int dc, last;
    dc = done_cycle(d, n);
    last = (abort_at > 0 && abort_at < dc + 1) ? abort_at : dc + 1;
    div_i   = 16'(d);
    nbits_i = 6'(n);
    cpol    = pol;
    cpha    = pha;
    start   = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("frame d=%0d n=%0d pol=%0d pha=%0d k=%0d", d, n, pol, pha, k),
            model(k, d, n, pol, pha));
      if (k == 1) begin
        // Latched parameters must ignore mid-frame input changes.
        div_i   = 16'($urandom_range(0, 7));
        nbits_i = 6'($urandom_range(0, 63));
        cpha    = 1'($urandom);
      end
      if (hold) start = 1'b1;
      else if (k <= dc) start = ($urandom_range(0, 3) == 0);
      else start = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    cpol    = 1'b1;
    cpha    = 1'b0;
    div_i   = '0;
    nbits_i = '0;
    #1;
    check("reset_async", 7'b0);
    @(negedge clk);
    check("reset_held", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_idle_loads_cpol", 7'b1000000);
    cpol = 1'b0;
    @(negedge clk);
    check("idle_cpol_0", 7'b0000000);
    cpol = 1'b1;
    @(negedge clk);
    check("idle_cpol_1", 7'b1000000);
    cpol = 1'b0;
    @(negedge clk);
    check("idle_cpol_back", 7'b0000000);

    run_frame(1, 2, 1'b0, 1'b0, 1'b0, 0);
    run_frame(1, 2, 1'b1, 1'b1, 1'b0, 0);
    run_frame(0, 8, 1'b0, 1'b0, 1'b0, 0);
    run_frame(0, 0, 1'b0, 1'b1, 1'b0, 0);
    run_frame(3, 0, 1'b1, 1'b0, 1'b0, 0);
    // Start held high: each frame re-enters IDLE for exactly one cycle.
    run_frame(0, 1, 1'b0, 1'b0, 1'b1, 0);
    run_frame(0, 1, 1'b0, 1'b0, 1'b1, 0);
    run_frame(0, 1, 1'b0, 1'b0, 1'b0, 0);

    // Abort after the third edge (cycle T+7 for div=1).
    run_frame(1, 4, 1'b1, 1'b0, 1'b0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", 7'b0);
    @(negedge clk);
    check("abort_no_done", 7'b0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_idle", 7'b1000000);
    run_frame(1, 4, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                1'($urandom), 1'($urandom), 1'b0, 0);
    end
    start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 Parameter DIV_W, default 16, width of the runtime half-period divider.
REQ-002 Parameter CNT_W, default 6, width of the per-frame bit count.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  frame request, sampled in IDLE only.
REQ-006 cpol  input  1  idle level of sclk.
REQ-007 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-008 div  input  DIV_W  half-period length minus one, in clk cycles.
REQ-009 nbits  input  CNT_W  SCLK cycles per frame.
REQ-010 sclk  output  1  registered serial clock.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 lead_stb / trail_stb  output  1 each  one-cycle pulse in the cycle sclk shows a leading / trailing edge.
REQ-013 sample_stb / shift_stb  output  1 each  one-cycle data-path strobes derived from the edge strobes and latched cpha.
REQ-014 done  output  1  one-cycle end-of-frame pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE (plus GUARD under REQ-029); IDLE->RUN on start, RUN->DONE after the final edge, DONE->IDLE unconditionally.
REQ-016 On accepted start, div, nbits, cpol and cpha SHALL be latched; input changes during a frame SHALL have no effect.
REQ-017 In IDLE, sclk SHALL load cpol each cycle, so an idle cpol change is visible one cycle later.
REQ-018 In RUN, a half-period counter SHALL clear on entry, increment each cycle, and, on reaching latched div, clear and toggle sclk in the next cycle.
REQ-019 The first edge SHALL appear div+2 cycles after the start-sampling cycle; subsequent edges SHALL be div+1 cycles apart; div=0 gives sclk = clk/2.
REQ-020 An edge counter of CNT_W+1 bits SHALL count edges; a frame SHALL contain exactly 2*nbits edges, alternating leading/trailing, starting with leading.
REQ-021 Strobes SHALL be registered and coincide with the sclk change (zero synchroniser latency).
REQ-022 sample_stb = lead_stb when cpha=0, trail_stb when cpha=1; shift_stb is the complementary edge strobe.
REQ-023 done SHALL pulse, and busy SHALL fall, in the cycle after the final edge; sclk SHALL then equal latched cpol.
REQ-024 nbits=0: start SHALL be accepted, no edges or strobes produced, done pulsing two cycles after the start-sampling cycle.
REQ-025 start while busy, or during DONE, SHALL be ignored; start held high SHALL produce back-to-back frames, each re-entering IDLE for one cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counters 0, sclk 0, busy/done and all strobes 0, aborting any frame without a done pulse.
REQ-027 The first cycle after rst_n release SHALL be IDLE, with sclk loading cpol per REQ-017.

Configuration
REQ-028 Macro SPI_SCLK_ENGINE_GUARD_EN selects a post-frame guard interval for chip-select hold time.
REQ-029 Defined: RUN SHALL pass through GUARD, holding sclk at cpol for div+1 cycles after the final edge, before DONE; done and busy fall are delayed by div+1 cycles. Undefined: the GUARD state and its logic are absent and REQ-023 timing applies.

Verification
REQ-030 div=1, nbits=2, cpol=0, cpha=0, start at T: busy=1 T+1..T+9; sclk rises T+3, T+7, falls T+5, T+9; sample_stb T+3, T+7; shift_stb T+5, T+9; done T+10.
REQ-031 Same as REQ-030 with cpol=1, cpha=1: sclk inverted, lead_stb at falls T+3, T+7, sample_stb at T+5, T+9, done T+10.
REQ-032 div=0, nbits=8: 16 edges one cycle apart, sample_stb count 8, done 18 cycles after start; div/nbits changed mid-frame have no effect.
REQ-033 rst_n pulsed low mid-frame after edge 3: sclk, busy and strobes 0 asynchronously, no done; the next start runs a complete frame.
REQ-034 nbits=0: done at T+2, no strobes; start held high with nbits=1, div=0: consecutive frames separated by exactly one IDLE cycle.
REQ-035 With SPI_SCLK_ENGINE_GUARD_EN, REQ-030 stimulus: done at T+12, sclk stays 0 after T+9.
